// File: rtl/fp16_div_pkg.sv
// Shared types and constants for the binary16 Newton-Raphson divider.
package fp16_div_pkg;

  localparam int          BIAS    = 15;
  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam int          SEED_W  = 11;
  localparam int          IDX_W   = 5;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    NR_MUL,
    NR_SUB,
    QMUL,
    DONE
  } div_state_e;

  typedef struct packed {
    logic       sign;
    logic [4:0] expo;
    logic [9:0] man;
  } fp16_t;

endpackage

// File: rtl/fp16_recip_seed.sv
// Reciprocal seed table: seed = round(2048 / (1 + (idx + 0.5)/32)), i.e. 1/1.mb
// at the midpoint of each 1/32 interval, 11 fractional bits.
module fp16_recip_seed
  import fp16_div_pkg::*;
(
  input  logic [IDX_W-1:0]  idx_i,
  output logic [SEED_W-1:0] seed_o
);

  // Pure lookup, no state.
  always_comb begin
    seed_o = 11'd2016;
    unique case (idx_i)
      5'd0:  seed_o = 11'd2016;
      5'd1:  seed_o = 11'd1956;
      5'd2:  seed_o = 11'd1900;
      5'd3:  seed_o = 11'd1846;
      5'd4:  seed_o = 11'd1796;
      5'd5:  seed_o = 11'd1748;
      5'd6:  seed_o = 11'd1702;
      5'd7:  seed_o = 11'd1659;
      5'd8:  seed_o = 11'd1618;
      5'd9:  seed_o = 11'd1579;
      5'd10: seed_o = 11'd1542;
      5'd11: seed_o = 11'd1507;
      5'd12: seed_o = 11'd1473;
      5'd13: seed_o = 11'd1440;
      5'd14: seed_o = 11'd1409;
      5'd15: seed_o = 11'd1380;
      5'd16: seed_o = 11'd1351;
      5'd17: seed_o = 11'd1324;
      5'd18: seed_o = 11'd1298;
      5'd19: seed_o = 11'd1273;
      5'd20: seed_o = 11'd1248;
      5'd21: seed_o = 11'd1225;
      5'd22: seed_o = 11'd1202;
      5'd23: seed_o = 11'd1181;
      5'd24: seed_o = 11'd1160;
      5'd25: seed_o = 11'd1140;
      5'd26: seed_o = 11'd1120;
      5'd27: seed_o = 11'd1101;
      5'd28: seed_o = 11'd1083;
      5'd29: seed_o = 11'd1066;
      5'd30: seed_o = 11'd1049;
      5'd31: seed_o = 11'd1032;
      default: seed_o = 11'd2016;
    endcase
  end

endmodule

// File: rtl/fp16_nr_div.sv
// binary16 divider: seed lookup, one Newton-Raphson step, quotient multiply.
// One multiply per FSM state, every product registered before use.
module fp16_nr_div
  import fp16_div_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] opa_i,
  input  logic [15:0] opb_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [15:0] result_o,
  output logic        dz_o,
  output logic        nv_o
);

  div_state_e        state_q, state_d;
  fp16_t             a_q, a_d, b_q, b_d;
  logic [SEED_W-1:0] y0_q, y0_d, seed;
  logic [21:0]       p_q, p_d;     // 1.mb * y0, 21 frac bits
  logic [24:0]       y1_q, y1_d;   // y0*(2 - 1.mb*y0), 24 frac bits
  logic [15:0]       res_q, res_d;
  logic              dz_q, dz_d, nv_q, nv_d;

  fp16_recip_seed u_seed (
    .idx_i  (b_q.man[9:10-IDX_W]),
    .seed_o (seed)
  );

  // Datapath: each product feeds a register, never another multiplier.
  logic [10:0] ma1, mb1;
  logic        bypass;
  logic [21:0] p_w;
  logic [22:0] t_w;
  logic [33:0] y1_w;
  logic [35:0] q_w;
  logic        nshift;
  logic [9:0]  man_n;
  logic [7:0]  exp_w;
  logic signed [7:0] exp_s;
  logic        sgn;
  logic        unused_bits;

  assign ma1    = {1'b1, a_q.man};
  assign mb1    = {1'b1, b_q.man};
  assign bypass = (b_q.man == 10'd0);
  assign p_w    = {11'd0, mb1} * {11'd0, y0_q};
  assign t_w    = 23'h40_0000 - {1'b0, p_q};          // 2.0 - p, 21 frac bits
  assign y1_w   = {23'd0, y0_q} * {11'd0, t_w};       // 32 frac bits
  assign q_w    = {25'd0, ma1} * {11'd0, y1_q};       // 34 frac bits, < 2.0
  assign nshift = ~q_w[34];
  assign man_n  = q_w[34] ? q_w[33:24] : q_w[32:23];
  assign exp_w  = {3'd0, a_q.expo} - {3'd0, b_q.expo} + 8'(BIAS) - {7'd0, nshift};
  assign exp_s  = exp_w;
  assign sgn    = a_q.sign ^ b_q.sign;
  assign unused_bits = ^{q_w[35], q_w[22:0], y1_w[33], y1_w[7:0]};

  // Operand classes; subnormals count as zero.
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  assign a_zero = (a_q.expo == 5'd0);
  assign b_zero = (b_q.expo == 5'd0);
  assign a_inf  = (a_q.expo == 5'h1F) && (a_q.man == 10'd0);
  assign b_inf  = (b_q.expo == 5'h1F) && (b_q.man == 10'd0);
  assign a_nan  = (a_q.expo == 5'h1F) && (a_q.man != 10'd0);
  assign b_nan  = (b_q.expo == 5'h1F) && (b_q.man != 10'd0);
  assign a_snan = a_nan && !a_q.man[9];
  assign b_snan = b_nan && !b_q.man[9];

  // Final result: special cases override the normalized/clamped quotient.
  logic [15:0] res_w;
  logic        dz_w, nv_w;
  always_comb begin
    dz_w = 1'b0;
    nv_w = 1'b0;
    if (exp_s <= 8'sd0)       res_w = {sgn, 15'd0};
    else if (exp_s >= 8'sd31) res_w = {sgn, POS_INF[14:0]};
    else                      res_w = {sgn, exp_s[4:0], man_n};
    if (a_nan || b_nan) begin
      res_w = QNAN;
      nv_w  = a_snan || b_snan;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      res_w = QNAN;
      nv_w  = 1'b1;
    end else if (a_inf) begin
      res_w = {sgn, POS_INF[14:0]};
    end else if (b_zero) begin
      res_w = {sgn, POS_INF[14:0]};
      dz_w  = 1'b1;
    end else if (a_zero || b_inf) begin
      res_w = {sgn, 15'd0};
    end
  end

  // Next-state and register updates per FSM state.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    y0_d    = y0_q;
    p_d     = p_q;
    y1_d    = y1_q;
    res_d   = res_q;
    dz_d    = dz_q;
    nv_d    = nv_q;
    unique case (state_q)
      IDLE: if (in_valid_i) begin
        a_d     = opa_i;
        b_d     = opb_i;
        state_d = SEED;
      end
      SEED: begin
        y0_d    = seed;
        state_d = NR_MUL;
      end
      NR_MUL: begin
        p_d     = p_w;
        state_d = NR_SUB;
      end
      NR_SUB: begin
        // Power-of-two divisor: exact reciprocal 1.0 keeps ma untouched.
        y1_d    = bypass ? 25'h100_0000 : y1_w[32:8];
        state_d = QMUL;
      end
      QMUL: begin
        res_d   = res_w;
        dz_d    = dz_w;
        nv_d    = nv_w;
        state_d = DONE;
      end
      DONE: if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      y0_q    <= '0;
      p_q     <= '0;
      y1_q    <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
      nv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      y0_q    <= y0_d;
      p_q     <= p_d;
      y1_q    <= y1_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
      nv_q    <= nv_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign result_o    = res_q;
  assign dz_o        = dz_q;
  assign nv_o        = nv_q;

endmodule

// File: tb/tb_fp16_nr_div.sv
// Bench for fp16_nr_div: integer-division reference model with an error
// window, per-cycle protocol checks, directed corner cases and random traffic.
module tb_fp16_nr_div;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, dz, nv;
  logic [15:0] opa, opb, result;

  fp16_nr_div dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .opa_i       (opa),
    .opb_i       (opb),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .dz_o        (dz),
    .nv_o        (nv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int LAT = 5;  // cycle after the accept edge is cycle 1

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Normalize a 20-frac-bit quotient, then truncate and clamp.
  function automatic logic [15:0] pack_q(input logic s, input int e0, input longint num);
    int e = e0;
    longint n = num;
    if (n <= 0) return {s, 15'd0};
    while (n < 1048576) begin n = n * 2; e--; end
    if (e <= 0) return {s, 15'd0};
    if (e >= 31) return {s, 5'h1F, 10'd0};
    return {s, 5'(e), 10'(n >> 10)};
  endfunction

  // Reference: hi = truncated exact quotient; lo allows ~1 ulp of NR error.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] lo, output logic [15:0] hi,
                                output logic mdz, output logic mnv);
    int ea = int'(a[14:10]);
    int eb = int'(b[14:10]);
    int ma = int'(a[9:0]);
    int mb = int'(b[9:0]);
    logic s = a[15] ^ b[15];
    bit az = (ea == 0), bz = (eb == 0);
    bit ai = (ea == 31) && (ma == 0), bi = (eb == 31) && (mb == 0);
    bit an = (ea == 31) && (ma != 0), bn = (eb == 31) && (mb != 0);
    longint num;
    mdz = 1'b0;
    mnv = 1'b0;
    if (an || bn) begin
      hi = 16'h7E00;
      mnv = (an && !a[9]) || (bn && !b[9]);
    end else if ((az && bz) || (ai && bi)) begin
      hi = 16'h7E00;
      mnv = 1'b1;
    end else if (ai) hi = {s, 15'h7C00};
    else if (bz) begin
      hi = {s, 15'h7C00};
      mdz = 1'b1;
    end else if (az || bi) hi = {s, 15'd0};
    else begin
      num = (longint'(1024 + ma) << 20) / longint'(1024 + mb);
      hi = pack_q(s, ea - eb + 15, num);
      lo = pack_q(s, ea - eb + 15, num - num / 1024 - 1);
      return;
    end
    lo = hi;
  endfunction

  function automatic logic [15:0] rnd_fp();
    logic s = 1'($urandom);
    case ($urandom_range(0, 15))
      0: return {s, 15'd0};
      1: return {s, 5'h1F, 10'd0};
      2: return {s, 5'h1F, 1'b1, 9'($urandom)};
      3: return {s, 5'h1F, 1'b0, 9'($urandom_range(1, 511))};
      4: return {s, 5'd0, 10'($urandom_range(1, 1023))};
      5: return {s, 5'($urandom_range(1, 30)), 10'd0};
      6, 7, 8: return {s, 5'($urandom_range(1, 30)), 10'($urandom)};
      default: return {s, 5'($urandom_range(8, 22)), 10'($urandom)};
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          acc;
  } txn_t;

  txn_t        sb[$];
  txn_t        mon_t;
  int          cyc = 0;
  bit          in_rst = 0, started = 0, head_seen = 0, ev;
  logic [15:0] held_res, last_res, m_lo, m_hi;
  logic        held_dz, held_nv, last_dz, last_nv, m_dz, m_nv;

  always @(posedge clk) begin
    cyc++;
    in_rst = !rst_n;
    if (!rst_n) begin
      started = 1;
      sb.delete();
      head_seen = 0;
    end else begin
      if (out_valid === 1'b1 && out_ready && sb.size() > 0) begin
        void'(sb.pop_front());
        head_seen = 0;
      end
      if (in_valid && in_ready === 1'b1) begin
        mon_t.a = opa; mon_t.b = opb; mon_t.acc = cyc;
        sb.push_back(mon_t);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      if (in_rst) begin
        check("rst_valid", out_valid === 1'b0, out_valid, 0);
        check("rst_ready", in_ready === 1'b1, in_ready, 1);
        check("rst_result", result === 16'h0000 && dz === 1'b0 && nv === 1'b0, {dz, nv, result}, 0);
      end else begin
        ev = 0;
        if (sb.size() > 0) ev = head_seen || ((cyc - sb[0].acc + 1) == LAT);
        check("out_valid", out_valid === ev, out_valid, ev);
        check("in_ready", in_ready === (sb.size() == 0), in_ready, sb.size() == 0);
        if (out_valid === 1'b1 && ev) begin
          if (!head_seen) begin
            model(sb[0].a, sb[0].b, m_lo, m_hi, m_dz, m_nv);
            check("result", result[15] === m_hi[15] && result[14:0] >= m_lo[14:0]
                  && result[14:0] <= m_hi[14:0], {sb[0].a, result}, {m_lo, m_hi});
            check("dz", dz === m_dz, dz, m_dz);
            check("nv", nv === m_nv, nv, m_nv);
            held_res = result; held_dz = dz; held_nv = nv;
            last_res = result; last_dz = dz; last_nv = nv;
            head_seen = 1;
          end else begin
            check("stable", result === held_res && dz === held_dz && nv === held_nv,
                  {dz, nv, result}, {held_dz, held_nv, held_res});
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit early);
    int n = 0;
    while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    check("ready_wait", in_ready === 1'b1, in_ready, 1);
    opa = a; opb = b; in_valid = 1'b1; out_ready = early;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic finish(input int hold, output int lat);
    int n = 1;
    while (out_valid !== 1'b1 && n < 12) begin @(posedge clk); #1; n++; end
    lat = n;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); opa = 16'($urandom); opb = 16'($urandom);
      @(posedge clk); #1;
      check("hold_valid", out_valid === 1'b1, out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [15:0] d_a[8]  = '{16'h4600, 16'h3C00, 16'hBC00, 16'h0000, 16'h7BFF, 16'h0400, 16'h7C01, 16'h7E00};
  logic [15:0] d_b[8]  = '{16'h4000, 16'h4200, 16'h0000, 16'h0000, 16'h0400, 16'h7BFF, 16'h3C00, 16'h3C00};
  logic [15:0] d_lo[8] = '{16'h4200, 16'h3553, 16'hFC00, 16'h7E00, 16'h7C00, 16'h0000, 16'h7E00, 16'h7E00};
  logic [15:0] d_hi[8] = '{16'h4200, 16'h3555, 16'hFC00, 16'h7E00, 16'h7C00, 16'h0000, 16'h7E00, 16'h7E00};
  logic        d_dz[8] = '{0, 0, 1, 0, 0, 0, 0, 0};
  logic        d_nv[8] = '{0, 0, 0, 1, 0, 0, 1, 0};

  initial begin
    int lat;
    bit early;
    logic [15:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", in_ready === 1'b1, in_ready, 1);
    check("reset_valid", out_valid === 1'b0, out_valid, 0);
    check("reset_result", result === 16'h0000, result, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases with hand-computed answers.
    for (int i = 0; i < 8; i++) begin
      last_res = 'x;
      issue(d_a[i], d_b[i], 1'b0);
      finish(0, lat);
      check("dir_lat", lat == LAT, lat, LAT);
      check("dir_res", last_res[15:0] >= d_lo[i] && last_res[15:0] <= d_hi[i] && last_res[15] === d_hi[i][15],
            last_res, d_hi[i]);
      check("dir_flags", last_dz === d_dz[i] && last_nv === d_nv[i], {last_dz, last_nv}, {d_dz[i], d_nv[i]});
    end

    // Consumer stalls 10 cycles in DONE while in_valid pulses.
    last_res = 'x;
    issue(16'h4600, 16'h4000, 1'b0);
    finish(10, lat);
    check("hold_res", last_res === 16'h4200, last_res, 16'h4200);

    // Reset while the operation sits in NR_SUB.
    issue(16'h4600, 16'h4000, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b1; opa = 16'h3C00; opb = 16'h3C00;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    check("midrst_ready", in_ready === 1'b1, in_ready, 1);
    repeat (8) begin
      check("midrst_novalid", out_valid === 1'b0, out_valid, 0);
      @(posedge clk); #1;
    end
    last_res = 'x;
    issue(16'h4600, 16'h4000, 1'b0);
    finish(0, lat);
    check("postrst_res", last_res === 16'h4200, last_res, 16'h4200);

    // Random traffic against the model.
    for (int i = 0; i < 150; i++) begin
      ra = rnd_fp(); rb = rnd_fp();
      early = ($urandom_range(0, 3) == 0);
      issue(ra, rb, early);
      finish(early ? 0 : int'($urandom_range(0, 3)), lat);
      check("rnd_lat", lat == LAT, lat, LAT);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp16_nr_div.md
FP16_NR_DIV -- requirements
Module: fp16_nr_div

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_ni  input  1  reset, synchronous and active-low.
REQ-003 SHALL have port in_valid_i  input  1  operand pair valid.
REQ-004 SHALL have port in_ready_o  output  1  block can accept an operand pair.
REQ-005 SHALL have port opa_i  input  16  dividend, IEEE binary16.
REQ-006 SHALL have port opb_i  input  16  divisor, IEEE binary16.
REQ-007 SHALL have port out_valid_o  output  1  result_o valid.
REQ-008 SHALL have port out_ready_i  input  1  consumer accepts result.
REQ-009 SHALL have port result_o  output  16  quotient, binary16.
REQ-010 SHALL have port dz_o  output  1  divide-by-zero flag, valid with out_valid_o.
REQ-011 SHALL have port nv_o  output  1  invalid-operation flag, valid with out_valid_o.

Function
REQ-012 SHALL compute opa_i/opb_i as ma * y1 * 2^(ea-eb).
- y0: 11-bit reciprocal seed of 1.mb, indexed by mb[9:5].
- y1: one Newton-Raphson step, y1 = y0*(2 - 1.mb*y0), in unsigned fixed point ≥ 24 fractional bits.
REQ-013 SHALL implement FSM IDLE -> SEED -> NR_MUL -> NR_SUB -> QMUL -> DONE; every non-IDLE/non-DONE state lasts exactly one cycle.
REQ-014 SHALL assert in_ready_o only in IDLE; handshake in_valid_i & in_ready_o latches opa_i/opb_i and moves to SEED.
REQ-015 SHALL raise out_valid_o exactly 5 cycles after the accepting edge, for every input class including specials.
REQ-016 SHALL hold result_o, dz_o, nv_o and out_valid_o stable in DONE until out_ready_i is high, then return to IDLE on that edge.
REQ-017 SHALL NOT accept a new operand in the cycle DONE is consumed; next accept no earlier than the following cycle.
REQ-018 SHALL set sign of result = sign(a) XOR sign(b) for all non-NaN results.
REQ-019 SHALL compute exponent as ea - eb + 15, minus 1 when the quotient mantissa product is < 1.0 (one-bit left normalize).
REQ-020 SHALL truncate (round toward zero) the normalized mantissa to 10 bits; error ≤ 2 ulp versus exact quotient.
REQ-021 SHALL bypass the seed/NR path when mb == 0 (divisor power of two): mantissa = ma exactly.
REQ-022 SHALL treat subnormal inputs as signed zero (flush-to-zero).
REQ-023 SHALL flush results with biased exponent ≤ 0 to signed zero, and saturate exponent ≥ 31 to signed infinity.
REQ-024 SHALL handle special cases:
- any NaN input -> 16'h7E00, nv_o=1 only for signalling NaN;
- 0/0 or inf/inf -> 16'h7E00, nv_o=1;
- finite nonzero/0 -> signed inf, dz_o=1;
- 0/finite -> signed zero;
- inf/finite -> signed inf;
- finite/inf -> signed zero.
REQ-025 SHALL drive dz_o=0 and nv_o=0 for all other cases.

Reset
REQ-026 SHALL, with rst_ni low at a clock edge, enter IDLE and set out_valid_o=0, result_o=16'h0000, dz_o=0, nv_o=0, in_ready_o=1 after that edge.
REQ-027 SHALL, on reset mid-operation (any state), discard the in-flight operation with no output produced.
REQ-028 SHALL ignore in_valid_i while rst_ni is low.

Structure
REQ-029 SHALL place in shared package fp16_div_pkg:
- the FSM state enum;
- constants BIAS=15, QNAN=16'h7E00, POS_INF=16'h7C00;
- seed width 11 and index width 5.
REQ-030 SHALL place the 32-entry seed table in one combinational sub-module, fp16_recip_seed: 5-bit index in, 11-bit seed out.
REQ-031 SHALL register every multiplier output between FSM states; no two multiplies chained within one cycle.

Verification
REQ-032 SHALL cover: 0x4600 / 0x4000 (6.0/2.0) -> 0x4200 exactly, dz_o=0, nv_o=0, out_valid_o 5 cycles after accept.
REQ-033 SHALL cover: 0x3C00 / 0x4200 (1.0/3.0) -> within 2 ulp of 0x3555, sign 0.
REQ-034 SHALL cover: 0xBC00 / 0x0000 -> 0xFC00, dz_o=1; and 0x0000 / 0x0000 -> 0x7E00, nv_o=1.
REQ-035 SHALL cover: 0x7BFF / 0x0400 (max/min normal) -> 0x7C00; 0x0400 / 0x7BFF -> 0x0000.
REQ-036 SHALL cover: out_ready_i held low for 10 cycles in DONE.
- Required: result_o stable for the whole interval.
- Required: in_ready_o=0 for the whole interval.
- Required: in_valid_i pulses ignored.
REQ-037 SHALL cover: rst_ni low for one cycle while in NR_SUB.
- Required: no out_valid_o for that operation.
- Required: in_ready_o=1 on the next cycle.
- Required: a subsequent 6.0/2.0 returns 0x4200.
